// File: rtl/cen_gen_multi.sv
// cen_gen_multi: multi-channel fractional clock-enable generator (rate clk*NUM/DEN per channel),
// held off until the synchronised PLL lock has been stable for SETTLE_CYC cycles.
module cen_gen_multi #(
    parameter int CHANNELS   = 3,
    parameter int ACC_W      = 16,
    parameter int SETTLE_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic                      cfg_load,
    input  logic [CHANNELS*ACC_W-1:0] cfg_num,
    input  logic [CHANNELS*ACC_W-1:0] cfg_den,
    output logic [CHANNELS-1:0]       cen,
    output logic                      locked,
    output logic [CHANNELS-1:0]       cfg_err,
    output logic                      lock_lost
);
    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] SETTLE    = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lk_q, lk_s, run;
    logic [ACC_W-1:0] num_r [CHANNELS];
    logic [ACC_W-1:0] den_r [CHANNELS];
    logic [ACC_W-1:0] acc [CHANNELS];
    logic [ACC_W-1:0] acc_nx [CHANNELS];
    logic [ACC_W:0]   sum [CHANNELS];
    logic [ACC_W:0]   diff [CHANNELS];
    logic [CHANNELS-1:0] hit, active;

    // a lock drop seen in RUN already stops the accumulators in that cycle
    assign run    = state == RUN && lk_s;
    assign locked = state == RUN;

    always_comb begin
        hit    = '0;
        active = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]    = {1'b0, acc[i]} + {1'b0, num_r[i]};
            diff[i]   = sum[i] - {1'b0, den_r[i]};
            hit[i]    = sum[i] >= {1'b0, den_r[i]};
            active[i] = num_r[i] != '0 && den_r[i] != '0;
            acc_nx[i] = hit[i] ? diff[i][ACC_W-1:0] : sum[i][ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            lk_q      <= 1'b0;
            lk_s      <= 1'b0;
            cen       <= '0;
            cfg_err   <= '0;
            lock_lost <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                num_r[i] <= '0;
                den_r[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            lk_q <= pll_locked;
            lk_s <= lk_q;
            if (state == WAIT_LOCK) begin
                cnt <= '0;
                if (lk_s) state <= SETTLE;
            end else if (state == SETTLE) begin
                cnt <= cnt + CNT_W'(1);
                if (!lk_s) state <= WAIT_LOCK;
                else if (cnt == LAST) state <= RUN;
            end else if (state == RUN) begin
                if (!lk_s) begin
                    state     <= WAIT_LOCK;
                    lock_lost <= 1'b1;
                end
            end else begin
                state <= WAIT_LOCK;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_load) begin
                    // NUM>DEN is stored saturated so the channel fires every cycle
                    num_r[i]   <= (cfg_num[i*ACC_W +: ACC_W] > cfg_den[i*ACC_W +: ACC_W]) ?
                                  cfg_den[i*ACC_W +: ACC_W] : cfg_num[i*ACC_W +: ACC_W];
                    den_r[i]   <= cfg_den[i*ACC_W +: ACC_W];
                    cfg_err[i] <= cfg_num[i*ACC_W +: ACC_W] > cfg_den[i*ACC_W +: ACC_W];
                    acc[i]     <= '0;
                    cen[i]     <= 1'b0;
                end else if (run && active[i]) begin
                    acc[i] <= acc_nx[i];
                    cen[i] <= hit[i];
                end else begin
                    acc[i] <= '0;
                    cen[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cen_gen_multi.sv
// tb_cen_gen_multi: directed bench; expected strobe patterns come from floor(k*N/D) increments.
module tb_cen_gen_multi;
    logic        clk = 1'b0;
    logic        rst, pll_locked, cfg_load;
    logic [47:0] cfg_num, cfg_den;
    logic [2:0]  cen, cfg_err;
    logic        locked, lock_lost;
    int          n_tests = 0, n_fail = 0;
    int          mn [3], md [3];
    logic [2:0]  exp_q [$];
    int          cyc, viol, c0, c1, c2;

    cen_gen_multi #(.CHANNELS(3), .ACC_W(16), .SETTLE_CYC(16)) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .cfg_load(cfg_load),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cen(cen), .locked(locked),
        .cfg_err(cfg_err), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // strobe at RUN index k iff floor(k*N/D) steps up between k-1 and k
    function automatic logic exp_bit(input int k, input int n, input int d);
        int ns;
        if (d == 0 || n == 0 || k < 1) return 1'b0;
        ns = (n > d) ? d : n;
        return ((k * ns) / d) != (((k - 1) * ns) / d);
    endfunction

    task automatic load(input int n0, input int d0, input int n1, input int d1, input int n2, input int d2);
        cfg_num  = {16'(n2), 16'(n1), 16'(n0)};
        cfg_den  = {16'(d2), 16'(d1), 16'(d0)};
        mn[0] = n0; md[0] = d0; mn[1] = n1; md[1] = d1; mn[2] = n2; md[2] = d2;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic window(input int n, input string tag, output int o0, output int o1, output int o2);
        logic [2:0] v, e;
        o0 = 0; o1 = 0; o2 = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 3; i++) v[i] = exp_bit(k, mn[i], md[i]);
            exp_q.push_back(v);
        end
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            chk(tag, 32'(cen), 32'(e));
            o0 += int'(cen[0]); o1 += int'(cen[1]); o2 += int'(cen[2]);
            tick();
        end
    endtask

    task automatic wait_locked(input int glitch_at, output int c, output int bad);
        c = 0; bad = 0;
        while (c < 200) begin
            tick();
            c++;
            if (glitch_at > 0 && c == glitch_at) pll_locked = 1'b0;
            if (glitch_at > 0 && c == glitch_at + 1) pll_locked = 1'b1;
            if (locked) break;
            if (cen != 3'b000) bad++;
        end
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0; cfg_load = 1'b0; cfg_num = '0; cfg_den = '0;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_cen", 32'(cen), 0);
            chk("rst_locked", 32'(locked), 0);
            chk("rst_cfg_err", 32'(cfg_err), 0);
            chk("rst_lock_lost", 32'(lock_lost), 0);
        end
        rst = 1'b0;
        tick();
        chk("idle_locked", 32'(locked), 0);
        load(1, 4, 3, 8, 1, 18);
        chk("ratio_cfg_err", 32'(cfg_err), 0);
        pll_locked = 1'b1;
        wait_locked(0, cyc, viol);
        chk("settle_cycles", 32'(cyc), 19);
        chk("settle_cen_quiet", 32'(viol), 0);
        window(145, "ratio_cen", c0, c1, c2);
        chk("count_ch0", 32'(c0), 36);
        chk("count_ch1", 32'(c1), 54);
        chk("count_ch2", 32'(c2), 8);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        tick();
        chk("drop_locked", 32'(locked), 0);
        chk("drop_lock_lost", 32'(lock_lost), 1);
        chk("drop_cen", 32'(cen), 0);
        wait_locked(0, cyc, viol);
        chk("relock_cycles", 32'(cyc), 17);
        chk("relock_cen_quiet", 32'(viol), 0);
        window(40, "realign_cen", c0, c1, c2);
        pll_locked = 1'b0;
        for (int r = 0; r < 4; r++) tick();
        chk("wait_locked", 32'(locked), 0);
        pll_locked = 1'b1;
        wait_locked(8, cyc, viol);
        chk("settle_glitch_cycles", 32'(cyc), 28);
        chk("settle_glitch_cen_quiet", 32'(viol), 0);
        load(5, 3, 0, 7, 9, 0);
        chk("edge_cfg_err", 32'(cfg_err), 32'b101);
        window(20, "edge_cen", c0, c1, c2);
        chk("edge_count_ch0", 32'(c0), 19);
        load(1, 2, 1, 2, 1, 2);
        chk("half_cfg_err", 32'(cfg_err), 0);
        chk("half_lock_lost_sticky", 32'(lock_lost), 1);
        window(12, "half_cen", c0, c1, c2);
        pll_locked = 1'b0;
        tick();
        tick();
        load(1, 3, 4, 2, 1, 5);
        chk("simul_locked", 32'(locked), 0);
        chk("simul_cfg_err", 32'(cfg_err), 32'b010);
        chk("simul_cen", 32'(cen), 0);
        pll_locked = 1'b1;
        wait_locked(0, cyc, viol);
        chk("simul_relock_cycles", 32'(cyc), 19);
        window(30, "simul_cen", c0, c1, c2);
        rst = 1'b1;
        cfg_num = {16'd7, 16'd7, 16'd7};
        cfg_den = {16'd3, 16'd3, 16'd3};
        cfg_load = 1'b1;
        tick();
        rst = 1'b0;
        cfg_load = 1'b0;
        for (int i = 0; i < 3; i++) begin mn[i] = 0; md[i] = 0; end
        chk("rstload_cfg_err", 32'(cfg_err), 0);
        chk("rstload_lock_lost", 32'(lock_lost), 0);
        chk("rstload_locked", 32'(locked), 0);
        chk("rstload_cen", 32'(cen), 0);
        wait_locked(0, cyc, viol);
        chk("rstload_relock_cycles", 32'(cyc), 19);
        window(20, "rstload_cen", c0, c1, c2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
